// File: rtl/fc_accum.sv
// Fully-connected output stage: streams NUM flattened values against a weight ROM,
// accumulates with bias, then rounds, saturates, optionally rectifies and writes one result.
module fc_accum #(
  parameter int DATAW = 20,
  parameter int ADDRW = 12,
  parameter int FRAC  = 16,
  parameter int NUM   = 2048,
  parameter int RELU  = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [DATAW-1:0] i_bias,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_crd,
  output logic [ADDRW-1:0] o_caddr_rd,
  input  logic [DATAW-1:0] i_cdata_rd,
  output logic [ADDRW-1:0] o_waddr,
  input  logic [DATAW-1:0] i_wdata,
  output logic             o_cwr,
  output logic [2:0]       o_csel,
  output logic [ADDRW-1:0] o_caddr_wr,
  output logic [DATAW-1:0] o_cdata_wr
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | issuing reads k = 0..NUM-1, accumulating the previous product
  // DRAIN | accumulating the final product
  // WRITE | result on cdata_wr with cwr high
  // FIN   | done pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam int AW = 2*DATAW + $clog2(NUM) + 1;
  localparam logic [ADDRW-1:0] LAST = ADDRW'(NUM-1);
  localparam logic signed [AW-1:0] HALF    = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATAW+1){1'b0}}, {(DATAW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATAW+1){1'b1}}, {(DATAW-1){1'b0}}};

  logic [2:0]              r_state;
  logic [ADDRW-1:0]        r_cnt;
  logic signed [AW-1:0]    r_acc;
  logic                    r_vld;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_crd;
  logic                    r_cwr;
  logic [2:0]              r_csel;
  logic [DATAW-1:0]        r_cdata_wr;

  logic signed [2*DATAW-1:0] w_prod;
  logic signed [AW-1:0]      w_prod_ext;
  logic signed [AW-1:0]      w_acc_next;
  logic signed [AW-1:0]      w_shift;
  logic [DATAW-1:0]          w_sat;
  logic [DATAW-1:0]          w_final;
  logic signed [AW-1:0]      w_bias_ext;

  assign w_prod     = $signed(i_cdata_rd) * $signed(i_wdata);
  assign w_prod_ext = {{(AW-2*DATAW){w_prod[2*DATAW-1]}}, w_prod};
  assign w_acc_next = r_vld ? (r_acc + w_prod_ext) : r_acc;
  // Round half up, then arithmetic shift back to the data's fixed-point scale.
  assign w_shift    = (w_acc_next + HALF) >>> FRAC;
  assign w_bias_ext = {{(AW-DATAW-FRAC){i_bias[DATAW-1]}}, i_bias, {FRAC{1'b0}}};

  always_comb begin
    w_sat = w_shift[DATAW-1:0];
    if (w_shift > SAT_MAX)      w_sat = {1'b0, {(DATAW-1){1'b1}}};
    else if (w_shift < SAT_MIN) w_sat = {1'b1, {(DATAW-1){1'b0}}};
    w_final = w_sat;
    if (RELU != 0 && w_sat[DATAW-1]) w_final = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_vld      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_csel     <= 3'b000;
      r_cdata_wr <= '0;
    end else begin
      r_vld <= r_crd;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_READ;
            r_cnt      <= '0;
            r_acc      <= w_bias_ext;
            r_busy     <= 1'b1;
            r_crd      <= 1'b1;
            r_csel     <= 3'b101;
            r_cdata_wr <= '0;
          end
        end
        S_READ: begin
          r_acc <= w_acc_next;
          if (r_cnt == LAST) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
            r_crd   <= 1'b0;
            r_csel  <= 3'b000;
          end else begin
            r_cnt <= r_cnt + ADDRW'(1);
          end
        end
        S_DRAIN: begin
          r_acc      <= w_acc_next;
          r_cdata_wr <= w_final;
          r_cwr      <= 1'b1;
          r_csel     <= 3'b110;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          r_cwr   <= 1'b0;
          r_csel  <= 3'b000;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_FIN;
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_crd      = r_crd;
  assign o_caddr_rd = r_cnt;
  assign o_waddr    = r_cnt;
  assign o_cwr      = r_cwr;
  assign o_csel     = r_csel;
  assign o_caddr_wr = '0;
  assign o_cdata_wr = r_cdata_wr;

endmodule

// File: tb/tb_fc_accum.sv
// Bench for fc_accum: four instances (NUM=4/RELU=1, NUM=1/RELU=0, NUM=2048 with RELU=0 and 1)
// against an arithmetic reference model of the dot product, rounding, saturation and ReLU.
module tb_fc_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] bias;
  logic        st [3];

  logic        busy [4];
  logic        done [4];
  logic        crd  [4];
  logic        cwr  [4];
  logic [11:0] ra   [4];
  logic [11:0] wa   [4];
  logic [11:0] wra  [4];
  logic [2:0]  csel [4];
  logic [19:0] wd   [4];
  logic [19:0] rdd  [4];
  logic [19:0] rdw  [4];

  logic [19:0] mem_d [4096];
  logic [19:0] mem_w [4096];

  int checks = 0;
  int failures = 0;

  int o_done_cyc, o_busy_cnt, o_rd_cnt, o_wr_cnt, o_addr_err, o_csel_err, o_overlap, o_timeout;
  logic [19:0] o_wr_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      rdd[i] <= mem_d[ra[i]];
      rdw[i] <= mem_w[wa[i]];
    end
  end

  fc_accum #(.DATAW(20), .ADDRW(12), .FRAC(16), .NUM(4), .RELU(1)) u_n4 (
    .i_clk(clk), .i_reset(rst), .i_start(st[0]), .i_bias(bias),
    .o_busy(busy[0]), .o_done(done[0]), .o_crd(crd[0]), .o_caddr_rd(ra[0]),
    .i_cdata_rd(rdd[0]), .o_waddr(wa[0]), .i_wdata(rdw[0]), .o_cwr(cwr[0]),
    .o_csel(csel[0]), .o_caddr_wr(wra[0]), .o_cdata_wr(wd[0]));

  fc_accum #(.DATAW(20), .ADDRW(12), .FRAC(16), .NUM(1), .RELU(0)) u_n1 (
    .i_clk(clk), .i_reset(rst), .i_start(st[1]), .i_bias(bias),
    .o_busy(busy[1]), .o_done(done[1]), .o_crd(crd[1]), .o_caddr_rd(ra[1]),
    .i_cdata_rd(rdd[1]), .o_waddr(wa[1]), .i_wdata(rdw[1]), .o_cwr(cwr[1]),
    .o_csel(csel[1]), .o_caddr_wr(wra[1]), .o_cdata_wr(wd[1]));

  fc_accum #(.DATAW(20), .ADDRW(12), .FRAC(16), .NUM(2048), .RELU(0)) u_big0 (
    .i_clk(clk), .i_reset(rst), .i_start(st[2]), .i_bias(bias),
    .o_busy(busy[2]), .o_done(done[2]), .o_crd(crd[2]), .o_caddr_rd(ra[2]),
    .i_cdata_rd(rdd[2]), .o_waddr(wa[2]), .i_wdata(rdw[2]), .o_cwr(cwr[2]),
    .o_csel(csel[2]), .o_caddr_wr(wra[2]), .o_cdata_wr(wd[2]));

  fc_accum #(.DATAW(20), .ADDRW(12), .FRAC(16), .NUM(2048), .RELU(1)) u_big1 (
    .i_clk(clk), .i_reset(rst), .i_start(st[2]), .i_bias(bias),
    .o_busy(busy[3]), .o_done(done[3]), .o_crd(crd[3]), .o_caddr_rd(ra[3]),
    .i_cdata_rd(rdd[3]), .o_waddr(wa[3]), .i_wdata(rdw[3]), .o_cwr(cwr[3]),
    .o_csel(csel[3]), .o_caddr_wr(wra[3]), .o_cdata_wr(wd[3]));

  // Reference: exact integer dot product, floor((acc + 0.5 LSB) / 2^16), clamp, ReLU.
  function automatic logic [19:0] model(input int num, input logic [19:0] b, input bit relu);
    longint acc, ld, lw, r;
    logic signed [19:0] sb, sd, sw;
    sb = b;
    acc = sb;
    acc = acc * 65536;
    for (int k = 0; k < num; k++) begin
      sd = mem_d[k];
      sw = mem_w[k];
      ld = sd;
      lw = sw;
      acc = acc + ld * lw;
    end
    r = (acc + 32768) >>> 16;
    if (r > 524287) r = 524287;
    if (r < -524288) r = -524288;
    if (relu && r < 0) r = 0;
    return r[19:0];
  endfunction

  function automatic logic [19:0] rnd_val(input int mode);
    logic [19:0] v;
    v = 20'($urandom);
    if (mode == 1) v = {{3{v[16]}}, v[16:0]};
    return v;
  endfunction

  // Starts instance sel (2 also starts the RELU=1 twin) and records what it does until done.
  task automatic run(input int sel, input int num, input logic [19:0] b);
    @(negedge clk);
    bias = b;
    st[sel] = 1'b1;
    o_done_cyc = -1; o_busy_cnt = 0; o_rd_cnt = 0; o_wr_cnt = 0;
    o_addr_err = 0; o_csel_err = 0; o_overlap = 0; o_timeout = 1; o_wr_data = '0;
    for (int c = 1; c <= num + 20; c++) begin
      @(negedge clk);
      if (c == 1) st[sel] = 1'b0;
      if (busy[sel]) o_busy_cnt++;
      if (crd[sel] && cwr[sel]) o_overlap++;
      if (crd[sel]) begin
        if (ra[sel] != 12'(o_rd_cnt) || wa[sel] != ra[sel]) o_addr_err++;
        if (csel[sel] != 3'b101) o_csel_err++;
        o_rd_cnt++;
      end else if (cwr[sel]) begin
        if (csel[sel] != 3'b110 || wra[sel] != 12'd0) o_csel_err++;
        o_wr_cnt++;
        o_wr_data = wd[sel];
      end else if (csel[sel] != 3'b000) begin
        o_csel_err++;
      end
      if (done[sel]) begin
        if (busy[sel]) o_csel_err++;
        o_done_cyc = c;
        o_timeout = 0;
        break;
      end
    end
    if (o_timeout != 0) begin
      failures++;
      $display("FAIL run_timeout: instance %0d gave no done within %0d cycles", sel, num + 20);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy[i], done[i], crd[i], cwr[i], csel[i], ra[i], wa[i], wra[i], wd[i]} !== 59'd0) begin
        failures++;
        $display("FAIL reset_outputs: inst %0d got busy=%b done=%b crd=%b cwr=%b csel=%b ra=%h wd=%h want all 0",
                 i, busy[i], done[i], crd[i], cwr[i], csel[i], ra[i], wd[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) begin mem_d[k] = 20'h10000; mem_w[k] = 20'h10000; end
    run(0, 4, 20'h0);
    checks++;
    if (o_rd_cnt != 4 || o_addr_err != 0) begin
      failures++; $display("FAIL basic_reads: got %0d reads, %0d addr errors, want 4 and 0", o_rd_cnt, o_addr_err);
    end
    checks++;
    if (o_done_cyc != 7) begin
      failures++; $display("FAIL basic_done_cycle: got %0d want 7", o_done_cyc);
    end
    checks++;
    if (o_busy_cnt != 6) begin
      failures++; $display("FAIL basic_busy_len: got %0d want 6", o_busy_cnt);
    end
    checks++;
    if (o_wr_cnt != 1 || o_wr_data !== 20'h40000) begin
      failures++; $display("FAIL basic_result: got %0d writes data %h want 1 write 40000", o_wr_cnt, o_wr_data);
    end
    checks++;
    if (o_overlap != 0 || o_csel_err != 0) begin
      failures++; $display("FAIL basic_protocol: got overlap=%0d csel_err=%0d want 0", o_overlap, o_csel_err);
    end
    @(negedge clk);
    checks++;
    if (wd[0] !== 20'h40000) begin
      failures++; $display("FAIL basic_hold: got %h want 40000", wd[0]);
    end
  endtask

  task automatic test_ramp();
    for (int k = 0; k < 4; k++) begin mem_d[k] = 20'(k); mem_w[k] = 20'h10000; end
    run(0, 4, 20'h08000);
    checks++;
    if (o_wr_cnt != 1 || o_wr_data !== 20'h08006) begin
      failures++; $display("FAIL ramp_result: got %0d writes data %h want 1 write 08006", o_wr_cnt, o_wr_data);
    end
    checks++;
    if (o_csel_err != 0 || o_addr_err != 0) begin
      failures++; $display("FAIL ramp_csel: got csel_err=%0d addr_err=%0d want 0", o_csel_err, o_addr_err);
    end
  endtask

  task automatic test_rounding();
    logic [19:0] dv [4];
    logic [19:0] ev [4];
    dv[0] = 20'h08000; ev[0] = 20'h00001;
    dv[1] = 20'h07FFF; ev[1] = 20'h00000;
    dv[2] = 20'hF8000; ev[2] = 20'h00000;
    dv[3] = 20'hF7FFF; ev[3] = 20'hFFFFF;
    for (int i = 0; i < 4; i++) begin
      mem_d[0] = dv[i]; mem_w[0] = 20'h00001;
      run(1, 1, 20'h0);
      checks++;
      if (o_wr_data !== ev[i] || o_done_cyc != 4) begin
        failures++; $display("FAIL round_%0d: got %h (done at %0d) want %h (done at 4)", i, o_wr_data, o_done_cyc, ev[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      logic [19:0] b, exp;
      mem_d[0] = rnd_val(i % 2); mem_w[0] = rnd_val(i % 2); b = rnd_val(1);
      exp = model(1, b, 1'b0);
      run(1, 1, b);
      checks++;
      if (o_wr_data !== exp) begin
        failures++; $display("FAIL round_rand_%0d: got %h want %h", i, o_wr_data, exp);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [19:0] b, exp;
      for (int k = 0; k < 4; k++) begin mem_d[k] = rnd_val(i % 2); mem_w[k] = rnd_val(i % 3 == 0 ? 0 : 1); end
      b = rnd_val(i % 2);
      exp = model(4, b, 1'b1);
      run(0, 4, b);
      checks++;
      if (o_wr_data !== exp || o_wr_cnt != 1 || o_addr_err != 0) begin
        failures++; $display("FAIL random_%0d: got %h (%0d writes, %0d addr err) want %h", i, o_wr_data, o_wr_cnt, o_addr_err, exp);
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 2048; k++) begin mem_d[k] = 20'h7FFFF; mem_w[k] = 20'h7FFFF; end
    run(2, 2048, 20'h0);
    checks++;
    if (wd[2] !== 20'h7FFFF || wd[3] !== 20'h7FFFF) begin
      failures++; $display("FAIL sat_pos: got %h/%h want 7ffff/7ffff", wd[2], wd[3]);
    end
    checks++;
    if (o_rd_cnt != 2048 || o_addr_err != 0 || o_busy_cnt != 2050 || o_done_cyc != 2051) begin
      failures++; $display("FAIL sat_timing: got reads=%0d addr_err=%0d busy=%0d done_at=%0d want 2048 0 2050 2051",
                           o_rd_cnt, o_addr_err, o_busy_cnt, o_done_cyc);
    end
    for (int k = 0; k < 2048; k++) mem_w[k] = 20'h80000;
    run(2, 2048, 20'h0);
    checks++;
    if (wd[2] !== 20'h80000) begin
      failures++; $display("FAIL sat_neg_norelu: got %h want 80000", wd[2]);
    end
    checks++;
    if (wd[3] !== 20'h00000) begin
      failures++; $display("FAIL sat_neg_relu: got %h want 00000", wd[3]);
    end
  endtask

  task automatic test_abort();
    int stray;
    logic [19:0] b, exp0, exp1;
    for (int k = 0; k < 2048; k++) begin mem_d[k] = rnd_val(1); mem_w[k] = rnd_val(1); end
    @(negedge clk);
    bias = 20'h01234;
    st[2] = 1'b1;
    for (int c = 1; c <= 101; c++) begin
      @(negedge clk);
      if (c == 1) st[2] = 1'b0;
      if (c == 11) st[2] = 1'b1;
      if (c == 12) st[2] = 1'b0;
      if (c == 13) begin
        checks++;
        if (ra[2] !== 12'd12 || crd[2] !== 1'b1) begin
          failures++; $display("FAIL abort_restart_ignored: got addr %0d crd %b want 12 1", ra[2], crd[2]);
        end
      end
    end
    checks++;
    if (ra[2] !== 12'd100) begin
      failures++; $display("FAIL abort_addr100: got %0d want 100", ra[2]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 2; i < 4; i++) begin
      checks++;
      if ({busy[i], done[i], crd[i], cwr[i], csel[i], ra[i], wa[i], wra[i], wd[i]} !== 59'd0) begin
        failures++; $display("FAIL abort_reset_outputs: inst %0d got busy=%b crd=%b csel=%b ra=%h want all 0",
                             i, busy[i], crd[i], csel[i], ra[i]);
      end
    end
    stray = 0;
    repeat (2060) begin
      @(negedge clk);
      if (busy[2] || cwr[2] || done[2] || busy[3] || cwr[3] || done[3]) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++; $display("FAIL abort_no_activity: got %0d active cycles want 0", stray);
    end
    b = rnd_val(1);
    exp0 = model(2048, b, 1'b0);
    exp1 = model(2048, b, 1'b1);
    run(2, 2048, b);
    checks++;
    if (wd[2] !== exp0 || wd[3] !== exp1 || o_wr_cnt != 1) begin
      failures++; $display("FAIL abort_fresh_run: got %h/%h want %h/%h", wd[2], wd[3], exp0, exp1);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] b1, b2, exp1, exp2;
    for (int k = 0; k < 4; k++) begin mem_d[k] = rnd_val(1); mem_w[k] = rnd_val(1); end
    b1 = 20'h30000;
    exp1 = model(4, b1, 1'b1);
    run(0, 4, b1);
    checks++;
    if (o_wr_data !== exp1) begin
      failures++; $display("FAIL b2b_first: got %h want %h", o_wr_data, exp1);
    end
    for (int k = 0; k < 4; k++) begin mem_d[k] = rnd_val(1); mem_w[k] = rnd_val(1); end
    b2 = 20'h00100;
    exp2 = model(4, b2, 1'b1);
    run(0, 4, b2);
    checks++;
    if (o_wr_data !== exp2 || o_done_cyc != 7) begin
      failures++; $display("FAIL b2b_second: got %h (done at %0d) want %h (done at 7)", o_wr_data, o_done_cyc, exp2);
    end
  endtask

  initial begin
    rst = 1'b1;
    bias = '0;
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    for (int k = 0; k < 4096; k++) begin mem_d[k] = '0; mem_w[k] = '0; end
    test_reset();
    test_basic();
    test_ramp();
    test_rounding();
    test_random();
    test_back_to_back();
    test_saturation();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
